instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 86 ++++++++
 rtl/instr_sequencer_call_stack.sv | 67 ++++++
 rtl/instr_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module  : instr_sequencer_pkg
// Purpose : Shared opcode map, ALU flag bit positions, instruction classes and
//           the decode helpers used by the instruction sequencer.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package instr_sequencer_pkg;

    // Opcode map (6-bit opcode field, instr[15:10])
    //   6'b00xxxx : ALU, register B-source
    //   6'b01xxxx : ALU, immediate B-source (operand_q)
    //   everything not listed below is illegal and executes as a NOP
    localparam logic [1:0] c_OP_ALU_PFX  = 2'b00;
    localparam logic [1:0] c_OP_ALUI_PFX = 2'b01;
    localparam logic [5:0] c_OP_LOAD     = 6'h20;
    localparam logic [5:0] c_OP_STORE    = 6'h21;
    localparam logic [5:0] c_OP_BRA      = 6'h28;
    localparam logic [5:0] c_OP_BRZ      = 6'h29;
    localparam logic [5:0] c_OP_BRN      = 6'h2A;
    localparam logic [5:0] c_OP_BRC      = 6'h2B;
    localparam logic [5:0] c_OP_BRO      = 6'h2C;
    localparam logic [5:0] c_OP_CALL     = 6'h30;
    localparam logic [5:0] c_OP_RET      = 6'h31;
    localparam logic [5:0] c_OP_HLT      = 6'h3F;

    // Bit positions inside the 4-bit ALU flag vector
    localparam int c_FLAG_Z = 3;
    localparam int c_FLAG_N = 2;
    localparam int c_FLAG_C = 1;
    localparam int c_FLAG_O = 0;

    typedef enum logic [3:0] {
        CL_ALU     = 4'd0,
        CL_ALUI    = 4'd1,
        CL_LOAD    = 4'd2,
        CL_STORE   = 4'd3,
        CL_BRANCH  = 4'd4,
        CL_CALL    = 4'd5,
        CL_RET     = 4'd6,
        CL_HLT     = 4'd7,
        CL_ILLEGAL = 4'd8
    } iclass_t;

    function automatic iclass_t classify(input logic [5:0] op);
        iclass_t cl;
        cl = CL_ILLEGAL;
        if (op[5:4] == c_OP_ALU_PFX) begin
            cl = CL_ALU;
        end else if (op[5:4] == c_OP_ALUI_PFX) begin
            cl = CL_ALUI;
        end else begin
            case (op)
                c_OP_LOAD:  cl = CL_LOAD;
                c_OP_STORE: cl = CL_STORE;
                c_OP_BRA, c_OP_BRZ, c_OP_BRN,
                c_OP_BRC, c_OP_BRO: cl = CL_BRANCH;
                c_OP_CALL:  cl = CL_CALL;
                c_OP_RET:   cl = CL_RET;
                c_OP_HLT:   cl = CL_HLT;
                default:    cl = CL_ILLEGAL;
            endcase
        end
        return cl;
    endfunction

    // Branch condition evaluated against the latched flag register
    function automatic logic branch_taken(input logic [5:0] op,
                                          input logic [3:0] fl);
        logic t;
        t = 1'b0;
        case (op)
            c_OP_BRA: t = 1'b1;
            c_OP_BRZ: t = fl[c_FLAG_Z];
            c_OP_BRN: t = fl[c_FLAG_N];
            c_OP_BRC: t = fl[c_FLAG_C];
            c_OP_BRO: t = fl[c_FLAG_O];
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_sequencer_call_stack.sv
//------------------------------------------------------------------------------
// Module  : call_stack
// Purpose : LIFO return-address stack for CALL/RET.
// Ports   : clk, rst        - clock, asynchronous active-high reset
//           push, push_data - store push_data on top (ignored when full)
//           pop             - discard top entry (ignored when empty)
//           full, empty     - occupancy status
//           data            - current top-of-stack entry
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module call_stack
    import instr_sequencer_pkg::*;
#(
    parameter int STK_DEPTH = 4,
    parameter int PC_W      = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [PC_W-1:0] push_data,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [PC_W-1:0] data
);

    localparam int PTR_W = $clog2(STK_DEPTH);
    localparam logic [PTR_W:0]   c_FULL    = (PTR_W+1)'(STK_DEPTH);
    localparam logic [PTR_W:0]   c_CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_IDX_ONE = PTR_W'(1);

    // One extra count bit distinguishes full from empty
    logic [PTR_W:0]   r_cnt;
    logic [PC_W-1:0]  r_mem [STK_DEPTH];
    logic [PTR_W-1:0] w_top;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_cnt == c_FULL);
    assign empty     = (r_cnt == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign w_top     = r_cnt[PTR_W-1:0] - c_IDX_ONE;
    assign data      = r_mem[w_top];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_do_push) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end else if (w_do_pop) begin
            r_cnt <= r_cnt - c_CNT_ONE;
        end
    end

    // Storage needs no reset: entries are only read below the count
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_cnt[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
//------------------------------------------------------------------------------
// Module  : instr_sequencer
// Purpose : Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT
//           with conditional branches, CALL/RET return stack and halting on
//           HLT or stack misuse.
// Ports   : clk, rst            - clock, asynchronous active-high reset
//           imem_req/imem_ack   - instruction fetch handshake, address = pc
//           instr               - fetched word {opcode[15:10], operand[9:0]}
//           RD/WR/dmem_ack      - data-memory request strobes and completion
//           flags / flags_q     - ALU flags in / latched flag register
//           opcode_q/operand_q  - instruction in flight
//           immediate, alu_op   - ALU controls during EXEC
//           reg_we              - register-file write strobe in WB
//           halt, stk_err       - terminal stop / sticky stack error
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int STK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_ack,
    input  logic [15:0]     instr,
    input  logic            dmem_ack,
    input  logic [3:0]      flags,
    output logic            imem_req,
    output logic [PC_W-1:0] pc,
    output logic [5:0]      opcode_q,
    output logic [9:0]      operand_q,
    output logic            immediate,
    output logic            alu_op,
    output logic            RD,
    output logic            WR,
    output logic            reg_we,
    output logic [3:0]      flags_q,
    output logic            halt,
    output logic            stk_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [PC_W-1:0] c_PC_ONE = PC_W'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_target;
    logic [5:0]      r_opcode;
    logic [9:0]      r_operand;
    logic [3:0]      r_flags;
    logic            r_stk_err;

    iclass_t         w_class;
    logic            w_latch;
    logic            w_flags_we;
    logic            w_err_set;
    logic            w_push;
    logic            w_pop;
    logic            w_stk_full;
    logic            w_stk_empty;
    logic [PC_W-1:0] w_stk_data;

    assign w_class  = classify(r_opcode);
    assign w_pc_inc = r_pc + c_PC_ONE;   // wraps modulo 2^PC_W
    assign w_target = PC_W'(r_operand);

    call_stack #(
        .STK_DEPTH (STK_DEPTH),
        .PC_W      (PC_W)
    ) u_call_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_pc_inc),
        .pop       (w_pop),
        .full      (w_stk_full),
        .empty     (w_stk_empty),
        .data      (w_stk_data)
    );

    //--------------------------------------------------------------------------
    // State and datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_opcode  <= '0;
            r_operand <= '0;
            r_flags   <= '0;
            r_stk_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_latch) begin
                r_opcode  <= instr[15:10];
                r_operand <= instr[9:0];
            end
            if (w_flags_we) begin
                r_flags <= flags;
            end
            if (w_err_set) begin
                r_stk_err <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Next state, pc update and Moore strobes
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_latch     = 1'b0;
        w_flags_we  = 1'b0;
        w_err_set   = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        imem_req    = 1'b0;
        alu_op      = 1'b0;
        immediate   = 1'b0;
        RD          = 1'b0;
        WR          = 1'b0;
        reg_we      = 1'b0;

        case (r_state)
            S_FETCH: begin
                // Held low while reset is asserted so that every strobe reads
                // zero during reset; the request then rises immediately on
                // release rather than one cycle later.
                imem_req = !rst;
                if (imem_ack) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end

            S_DECODE: begin
                w_state_nxt = S_EXEC;
            end

            S_EXEC: begin
                case (w_class)
                    CL_ALU, CL_ALUI: begin
                        alu_op      = 1'b1;
                        immediate   = (w_class == CL_ALUI);
                        w_flags_we  = 1'b1;
                        w_state_nxt = S_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        w_state_nxt = S_MEM;
                    end
                    CL_BRANCH: begin
                        w_pc_nxt    = branch_taken(r_opcode, r_flags) ? w_target : w_pc_inc;
                        w_state_nxt = S_FETCH;
                    end
                    CL_CALL: begin
                        if (w_stk_full) begin
                            w_err_set   = 1'b1;
                            w_state_nxt = S_HALT;
                        end else begin
                            w_push      = 1'b1;
                            w_pc_nxt    = w_target;
                            w_state_nxt = S_FETCH;
                        end
                    end
                    CL_RET: begin
                        if (w_stk_empty) begin
                            w_err_set   = 1'b1;
                            w_state_nxt = S_HALT;
                        end else begin
                            w_pop       = 1'b1;
                            w_pc_nxt    = w_stk_data;
                            w_state_nxt = S_FETCH;
                        end
                    end
                    CL_HLT: begin
                        w_state_nxt = S_HALT;
                    end
                    default: begin
                        // Illegal opcodes fall through as a NOP
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                // Only LOAD or STORE can reach this state
                RD = (w_class == CL_LOAD);
                WR = (w_class == CL_STORE);
                if (dmem_ack) begin
                    if (w_class == CL_LOAD) begin
                        w_state_nxt = S_WB;
                    end else begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = S_FETCH;
                    end
                end
            end

            S_WB: begin
                reg_we      = 1'b1;
                w_pc_nxt    = w_pc_inc;
                w_state_nxt = S_FETCH;
            end

            S_HALT: begin
                w_state_nxt = S_HALT;
            end

            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    assign pc        = r_pc;
    assign opcode_q  = r_opcode;
    assign operand_q = r_operand;
    assign flags_q   = r_flags;
    assign stk_err   = r_stk_err;
    assign halt      = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_instr_sequencer
// Purpose : Directed self-checking bench for instr_sequencer.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ack;
    logic [15:0] instr;
    logic        dmem_ack;
    logic [3:0]  flags;
    logic        imem_req;
    logic [9:0]  pc;
    logic [5:0]  opcode_q;
    logic [9:0]  operand_q;
    logic        immediate;
    logic        alu_op;
    logic        RD;
    logic        WR;
    logic        reg_we;
    logic [3:0]  flags_q;
    logic        halt;
    logic        stk_err;

    int n_tests = 0;
    int n_fail  = 0;

    instr_sequencer #(
        .PC_W      (10),
        .STK_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_ack  (imem_ack),
        .instr     (instr),
        .dmem_ack  (dmem_ack),
        .flags     (flags),
        .imem_req  (imem_req),
        .pc        (pc),
        .opcode_q  (opcode_q),
        .operand_q (operand_q),
        .immediate (immediate),
        .alu_op    (alu_op),
        .RD        (RD),
        .WR        (WR),
        .reg_we    (reg_we),
        .flags_q   (flags_q),
        .halt      (halt),
        .stk_err   (stk_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ins(input logic [5:0] op, input logic [9:0] opd);
        return {op, opd};
    endfunction

    // Starts at a FETCH sample point, ends at the EXEC sample point
    task automatic fetch(input logic [15:0] w, input int delay, input string tag);
        logic [9:0] pc0;
        pc0 = pc;
        for (int i = 0; i < delay; i++) begin
            imem_ack = 1'b0;
            tick();
            chk({tag, "_req_held"}, imem_req, 1);
            chk({tag, "_pc_held"}, pc, pc0);
        end
        imem_ack = 1'b1;
        instr    = w;
        tick();
        imem_ack = 1'b0;
        instr    = 16'h0000;
        tick();
    endtask

    initial begin
        int         rd_cnt;
        logic [9:0] exp_pc;

        rst      = 1'b1;
        imem_ack = 1'b0;
        instr    = 16'h0000;
        dmem_ack = 1'b0;
        flags    = 4'h0;
        tick();
        tick();

        // Reset state
        chk("rst_pc",       pc, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_halt",     halt, 0);
        chk("rst_stk_err",  stk_err, 0);
        chk("rst_flags_q",  flags_q, 0);
        chk("rst_opcode_q", opcode_q, 0);
        chk("rst_operand_q", operand_q, 0);
        chk("rst_strobes",  {RD, WR, reg_we, alu_op, immediate}, 0);

        rst = 1'b0;
        #1;
        chk("first_imem_req", imem_req, 1);

        // ALU-immediate with immediate ack: FETCH, DECODE, EXEC, WB
        fetch(ins(6'h12, 10'h005), 0, "alui");
        chk("alui_opcode_q",  opcode_q, 6'h12);
        chk("alui_operand_q", operand_q, 10'h005);
        chk("alui_alu_op",    alu_op, 1);
        chk("alui_immediate", immediate, 1);
        flags = 4'b1000;
        tick();
        flags = 4'b0000;
        chk("alui_reg_we_wb", reg_we, 1);
        chk("alui_flags_q",   flags_q, 4'b1000);
        chk("alui_pc_wb",     pc, 0);
        tick();
        chk("alui_reg_we_one", reg_we, 0);
        chk("alui_pc_next",    pc, 1);

        // LOAD with delayed imem_ack and dmem_ack delayed three cycles
        fetch(ins(c_OP_LOAD, 10'h044), 2, "load");
        chk("load_rd_exec", RD, 0);
        tick();
        rd_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (RD === 1'b1) rd_cnt++;
            if (i == 3) dmem_ack = 1'b1;
            tick();
        end
        dmem_ack = 1'b0;
        chk("load_rd_cycles", rd_cnt, 4);
        chk("load_rd_wb",     RD, 0);
        chk("load_reg_we",    reg_we, 1);
        tick();
        chk("load_pc", pc, 2);

        // BRZ taken with Z set
        fetch(ins(c_OP_BRZ, 10'h03F), 0, "brz_t");
        tick();
        chk("brz_taken_pc", pc, 10'h03F);

        // ALU register op clears flags_q
        fetch(ins(6'h03, 10'h001), 0, "alu");
        chk("alu_alu_op",    alu_op, 1);
        chk("alu_immediate", immediate, 0);
        tick();
        tick();
        chk("alu_pc",      pc, 10'h040);
        chk("alu_flags_q", flags_q, 0);

        // BRZ not taken with Z clear
        fetch(ins(c_OP_BRZ, 10'h03F), 0, "brz_n");
        tick();
        chk("brz_not_taken_pc", pc, 10'h041);

        // BRA always taken
        fetch(ins(c_OP_BRA, 10'h100), 0, "bra");
        tick();
        chk("bra_pc", pc, 10'h100);

        // STORE with immediate dmem_ack
        fetch(ins(c_OP_STORE, 10'h0AA), 0, "store");
        tick();
        chk("store_wr", WR, 1);
        chk("store_rd", RD, 0);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("store_wr_done", WR, 0);
        chk("store_no_wb",   reg_we, 0);
        chk("store_pc",      pc, 10'h101);

        // Illegal opcode is a NOP
        fetch(ins(6'h3A, 10'h000), 0, "ill");
        chk("ill_alu_op", alu_op, 0);
        tick();
        chk("ill_pc", pc, 10'h102);

        // pc wrap
        fetch(ins(c_OP_BRA, 10'h3FF), 0, "bra_max");
        tick();
        chk("bra_max_pc", pc, 10'h3FF);
        fetch(ins(6'h11, 10'h000), 0, "wrap");
        tick();
        tick();
        chk("pc_wrap", pc, 10'h000);

        // Four nested CALLs then four RETs
        for (int i = 0; i < 4; i++) begin
            exp_pc = 10'((i + 1) * 16);
            fetch(ins(c_OP_CALL, exp_pc), 0, "call");
            tick();
            chk("call_pc", pc, exp_pc);
        end
        for (int i = 0; i < 4; i++) begin
            exp_pc = 10'(10'h031 - i * 16);
            fetch(ins(c_OP_RET, 10'h000), 0, "ret");
            tick();
            chk("ret_pc", pc, exp_pc);
        end

        // Five nested CALLs: the fifth overflows
        for (int i = 0; i < 4; i++) begin
            exp_pc = 10'(10'h050 + i * 16);
            fetch(ins(c_OP_CALL, exp_pc), 0, "call2");
            tick();
            chk("call2_pc", pc, exp_pc);
        end
        fetch(ins(c_OP_CALL, 10'h090), 0, "call5");
        tick();
        chk("ovf_halt",     halt, 1);
        chk("ovf_stk_err",  stk_err, 1);
        chk("ovf_pc",       pc, 10'h080);
        chk("ovf_imem_req", imem_req, 0);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        tick();
        tick();
        tick();
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        chk("halt_sticky", halt, 1);
        chk("halt_strobes", {imem_req, RD, WR, reg_we, alu_op}, 0);
        chk("halt_pc", pc, 10'h080);

        // Reset clears halt and error
        rst = 1'b1;
        #1;
        chk("rst2_halt",    halt, 0);
        chk("rst2_stk_err", stk_err, 0);
        chk("rst2_pc",      pc, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst2_imem_req", imem_req, 1);

        // Reset asynchronously during a STORE in MEM
        fetch(ins(6'h10, 10'h000), 0, "pre");
        tick();
        tick();
        chk("pre_pc", pc, 1);
        fetch(ins(c_OP_STORE, 10'h055), 0, "store2");
        tick();
        chk("store2_wr", WR, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_wr_drop", WR, 0);
        chk("async_pc",      pc, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("async_refetch_req", imem_req, 1);
        chk("async_refetch_pc",  pc, 0);

        // RET on empty stack
        fetch(ins(c_OP_RET, 10'h000), 0, "ret_empty");
        tick();
        chk("udf_halt",    halt, 1);
        chk("udf_stk_err", stk_err, 1);
        chk("udf_pc",      pc, 0);

        // HLT opcode halts without a stack error
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        fetch(ins(c_OP_HLT, 10'h000), 0, "hlt");
        tick();
        chk("hlt_halt",     halt, 1);
        chk("hlt_stk_err",  stk_err, 0);
        chk("hlt_imem_req", imem_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
